soc_bus_fabric: RTL and testbench

- Parametrised memory-mapped interconnect between the multicycle CPU's data port and NUM_SLAVES slaves (RAM, CP0-adjacent peripherals, future I/O). It replaces the fixed point-to-point CPU/RAM wiring in the SoC top.
- Decodes the address, checks alignment, and runs a req/ack handshake with the selected slave.
- Enforces a timeout and reports MIPS-style exception cause codes so the CPU can forward faults to CP0.

---
 rtl/soc_bus_fabric.sv | 131 +++++++++++++
 tb/tb_soc_bus_fabric.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_fabric.sv
// Memory-mapped interconnect between the CPU data port and NUM_SLAVES slaves.
// Decodes the top address bits, checks alignment, runs req/ack with a timeout and reports MIPS cause codes.
module soc_bus_fabric #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [1:0]                   m_mask,
  input  logic                         m_signed_ext,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_done,
  output logic                         m_err,
  output logic [4:0]                   m_err_cause,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [1:0]                   s_mask,
  output logic                         s_signed_ext,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ack
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  // Width 1 minimum so a disabled timeout still yields a legal counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [SEL_BITS-1:0] idx;
  logic                idx_ok;
  logic                misalign;
  logic                ack_hit;
  logic                timeout_hit;
  logic [DATA_W-1:0]   rd_mux;

  assign idx         = m_addr[ADDR_W-1 -: SEL_BITS];
  assign idx_ok      = {{(32-SEL_BITS){1'b0}}, idx} < 32'(NUM_SLAVES);
  assign ack_hit     = |(s_ack & s_req);
  // The counter value before this cycle's increment hitting TIMEOUT-1 gives exactly TIMEOUT cycles of s_req.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_comb begin
    misalign = 1'b0;
    case (m_mask)
      2'b01:   misalign = m_addr[0];
      2'b10:   misalign = |m_addr[1:0];
      2'b11:   misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (s_req[i]) rd_mux = s_rdata[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      s_req        <= '0;
      s_we         <= 1'b0;
      s_addr       <= '0;
      s_mask       <= '0;
      s_signed_ext <= 1'b0;
      s_wdata      <= '0;
      m_rdata      <= '0;
      m_done       <= 1'b0;
      m_err        <= 1'b0;
      m_err_cause  <= '0;
    end else begin
      case (state)
        IDLE: if (m_req) begin
          if (misalign) begin
            state       <= ERR;
            m_err       <= 1'b1;
            m_err_cause <= m_we ? 5'd5 : 5'd4;
          end else if (!idx_ok) begin
            state       <= ERR;
            m_err       <= 1'b1;
            m_err_cause <= 5'd7;
          end else begin
            state        <= WAIT;
            s_req        <= NUM_SLAVES'(1) << idx;
            s_we         <= m_we;
            s_addr       <= m_addr;
            s_mask       <= m_mask;
            s_signed_ext <= m_signed_ext;
            s_wdata      <= m_wdata;
            cnt          <= '0;
          end
        end
        WAIT: begin
          if (ack_hit) begin
            if (!s_we) m_rdata <= rd_mux;
            s_req  <= '0;
            m_done <= 1'b1;
            state  <= DONE;
          end else if (timeout_hit) begin
            s_req       <= '0;
            m_err       <= 1'b1;
            m_err_cause <= 5'd7;
            state       <= ERR;
          end
          if (cnt != '1) cnt <= cnt + 1'b1;
        end
        DONE: begin
          m_done <= 1'b0;
          state  <= IDLE;
        end
        ERR: begin
          m_err       <= 1'b0;
          m_err_cause <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed plus randomized bench for soc_bus_fabric against a transaction-level outcome model.
module tb_soc_bus_fabric;
  localparam int NS = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_req, m_we, m_signed_ext;
  logic [31:0]   m_addr, m_wdata, m_rdata;
  logic [1:0]    m_mask;
  logic          m_done, m_err;
  logic [4:0]    m_err_cause;
  logic [NS-1:0] s_req, s_ack;
  logic          s_we, s_signed_ext;
  logic [31:0]   s_addr, s_wdata;
  logic [1:0]    s_mask;
  logic [NS*32-1:0] s_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_rd = '0;

  soc_bus_fabric #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(NS), .SEL_BITS(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_mask(m_mask),
    .m_signed_ext(m_signed_ext), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done),
    .m_err(m_err), .m_err_cause(m_err_cause), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_mask(s_mask), .s_signed_ext(s_signed_ext), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome model: 0 = goes to slave, otherwise the fault cause.
  function automatic int exp_cause(input logic we, input logic [31:0] addr, input logic [1:0] mask);
    int size;
    size = (mask == 2'd0) ? 1 : (mask == 2'd1) ? 2 : 4;
    if (mask == 2'd3 || (addr % size) != 0) return we ? 5 : 4;
    if ((addr >> 28) >= NS) return 7;
    return 0;
  endfunction

  // Slave acks on its (d+1)-th cycle of s_req; d >= TO means it never acks in time.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] mask,
                         input logic [31:0] wd, input int d, input bit stray);
    int cause, sl, high, exp_high, exp_cyc;
    bit fin;
    logic [31:0] rd;
    cause = exp_cause(we, addr, mask);
    sl    = int'(addr >> 28);
    rd    = $urandom;
    exp_high = (d >= TO) ? TO : d + 1;
    @(negedge clk);
    m_req = 1'b1; m_we = we; m_addr = addr; m_mask = mask; m_wdata = wd;
    m_signed_ext = addr[4];
    s_ack = '0;
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = ~rd ^ i;
    if (sl < NS) s_rdata[sl*32 +: 32] = rd;
    high = 0; fin = 0;
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(negedge clk);
      s_ack = '0;
      if (m_done || m_err) begin
        fin = 1; m_req = 1'b0;
        chk("done", m_done, cause == 0);
        chk("err", m_err, cause != 0);
        chk("cause", m_err_cause, (cause == 0) ? 0 : ((d >= TO && cause == 0) ? 7 : cause));
        chk("idle_sreq", s_req, 0);
        exp_cyc = (cause != 0) ? 1 : exp_high + 1;
        chk("latency", c, exp_cyc);
        if (cause == 0) chk("sreq_cycles", high, exp_high);
        if (cause == 0 && d < TO && !we) last_rd = rd;
        chk("rdata", m_rdata, last_rd);
      end else if (s_req != '0) begin
        high++;
        if (high == 1) begin
          chk("sreq_onehot", s_req, 4'b1 << sl);
          chk("s_fields", {s_we, s_mask, s_signed_ext, s_addr, s_wdata},
              {we, mask, addr[4], addr, wd});
        end
        if (high - 1 == d) s_ack[sl] = 1'b1;
        else if (stray) s_ack[(sl + 1) % NS] = 1'b1;
      end
    end
    chk("finished", fin, 1'b1);
  endtask

  // Timeout outcome differs from the model's decode view only in done/err/cause.
  task automatic run_to(input logic [31:0] addr, input int d);
    int high;
    bit fin;
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = addr; m_mask = 2'b10; m_wdata = '0; m_signed_ext = 1'b0;
    s_ack = '0;
    high = 0; fin = 0;
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(negedge clk);
      s_ack = '0;
      if (m_done || m_err) begin
        fin = 1; m_req = 1'b0;
        chk("to_err", m_err, d >= TO);
        chk("to_done", m_done, d < TO);
        chk("to_cause", m_err_cause, (d >= TO) ? 7 : 0);
        chk("to_sreq_cycles", high, (d >= TO) ? TO : d + 1);
        if (d < TO) last_rd = s_rdata[int'(addr >> 28)*32 +: 32];
      end else if (s_req != '0) begin
        high++;
        if (high - 1 == d) s_ack[int'(addr >> 28)] = 1'b1;
      end
    end
    chk("to_finished", fin, 1'b1);
  endtask

  initial begin
    int rise [2];
    int nr;
    reset = 1'b0; m_req = 0; m_we = 0; m_addr = '0; m_mask = '0; m_signed_ext = 0; m_wdata = '0;
    s_ack = '0; s_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {m_rdata, m_done, m_err, m_err_cause, s_req, s_we, s_addr, s_mask, s_signed_ext, s_wdata}, 0);
    reset = 1'b1;

    // Fastest word load, slave 0
    s_rdata[31:0] = 32'hDEADBEEF;
    @(negedge clk);
    m_req = 1; m_we = 0; m_addr = 32'h0000_0010; m_mask = 2'b10;
    @(negedge clk);
    chk("ld0_sreq", s_req, 4'b0001);
    s_ack = 4'b0001;
    @(negedge clk);
    s_ack = '0; m_req = 0;
    chk("ld0_done", {m_done, m_err}, 2'b10);
    chk("ld0_rdata", m_rdata, 32'hDEADBEEF);
    last_rd = 32'hDEADBEEF;

    run_txn(1'b1, 32'h3000_0004, 2'b10, 32'h12345678, 5, 1'b0);
    run_txn(1'b0, 32'h0000_0003, 2'b01, 32'h0, 0, 1'b0);
    run_txn(1'b1, 32'h0000_0002, 2'b10, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0000, 2'b11, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'h5000_0000, 2'b10, 32'h0, 0, 1'b0);
    run_to(32'h1000_0000, 20);
    run_to(32'h1000_0000, TO - 1);
    run_txn(1'b0, 32'h1000_0008, 2'b10, 32'h0, 3, 1'b1);

    // Back-to-back loads with m_req held high
    @(negedge clk);
    m_req = 1; m_we = 0; m_addr = 32'h2000_0000; m_mask = 2'b10;
    s_rdata[2*32 +: 32] = 32'hCAFE_0002;
    nr = 0;
    for (int c = 1; c <= 20 && nr < 2; c++) begin
      @(negedge clk);
      s_ack = '0;
      if (s_req != '0) begin
        rise[nr] = c; nr++;
        s_ack = s_req;
      end
    end
    @(negedge clk);
    s_ack = '0; m_req = 0;
    chk("b2b_count", nr, 2);
    chk("b2b_spacing", (nr == 2) ? rise[1] - rise[0] : -1, 3);
    chk("b2b_rdata", m_rdata, 32'hCAFE_0002);
    last_rd = 32'hCAFE_0002;
    repeat (3) @(negedge clk);

    // Reset in WAIT on slave 2
    m_req = 1; m_we = 0; m_addr = 32'h2000_0000; m_mask = 2'b10;
    @(negedge clk);
    chk("rstw_pre", s_req, 4'b0100);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstw_sreq", s_req, 0);
    chk("rstw_flags", {m_done, m_err}, 0);
    m_req = 0;
    @(negedge clk);
    chk("rstw_outs", {m_rdata, m_err_cause, s_we, s_addr, s_mask, s_wdata}, 0);
    reset = 1'b1;
    last_rd = '0;

    // Randomized traffic, some undecoded, misaligned, timed-out, with stray acks
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int dd;
      a  = {$urandom_range(0, 5), 28'(($urandom & 32'h0FFF_FFFF))};
      dd = $urandom_range(0, 10);
      if (dd >= TO && exp_cause(1'b0, a, 2'b10) == 0) run_to({a[31:2], 2'b00}, dd);
      else run_txn(1'($urandom), a, 2'($urandom), $urandom, dd % TO, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
